mem_stage_hs: RTL and testbench
===============================

Name: mem_stage_hs

Overview:
Parametrised successor to the single-cycle MEM slice of the 5-stage pipelined CPU. Resolves conditional branches from EX flags and drives a request/grant/response data-memory interface with variable latency. Stalls upstream while an access is outstanding and registers results into the MEM/WB pipeline register. Sits between the EX/MEM register and the WB stage.

Parameters:
DATA_W, 16, data/ALU word width
ADDR_W, 16, data address width
PC_W, 16, program counter width
TIMEOUT_CYC, 64, cycles before an outstanding access is aborted (used only with MEM_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  EX/MEM holds a valid instruction
in_ready  out  1  stage can accept; low = stall upstream
M  in  3  [0]=MemRead, [1]=MemWrite, [2]=is-branch
wb_ctrl_in  in  2  WB control, passed through
flags_in  in  3  {ov,neg,zr}
bcond  in  3  branch condition code
addr  in  ADDR_W  memory address
wdata  in  DATA_W  store data
pcbranch_in  in  PC_W  branch target
alu_in  in  DATA_W  ALU result
mem_req/mem_we  out  1/1  request valid / write enable
mem_addr/mem_wdata  out  ADDR_W/DATA_W  request address/data
mem_gnt  in  1  request accepted this cycle
mem_rvalid/mem_rdata  in  1/DATA_W  read response valid/data
branch_taken  out  1  take branch (combinational)
pc_branch  out  PC_W  = pcbranch_in
wb_valid  out  1  MEM/WB holds a retired instruction (1-cycle pulse)
wb_ctrl/wb_alu/wb_rdata  out  2/DATA_W/DATA_W  MEM/WB register
pc_ret  out  PC_W  = wb_rdata[PC_W-1:0] (return address from memory)
wb_err  out  1  access aborted

Behaviour:
- Reset (async, rst_n=0): state IDLE; mem_req, wb_valid, wb_err, wb_ctrl, wb_alu, wb_rdata, timeout counter all 0. Reset mid-access drops mem_req immediately; the access is abandoned, no retirement.
- FSM IDLE/REQ/RESP. in_ready = (state==IDLE). Accept = in_valid & in_ready.
- IDLE, accept, no mem op: next edge wb_valid=1, wb_alu=alu_in, wb_ctrl=wb_ctrl_in, wb_rdata holds; stays IDLE (1-cycle latency, full throughput).
- IDLE, accept, MemRead or MemWrite: capture addr/wdata/we/ctrl/alu; -> REQ. MemRead&MemWrite both set: treat as write.
- REQ: mem_req=1, signals stable until mem_gnt. Write+gnt: retire next edge, -> IDLE. Read+gnt: -> RESP; read+gnt+rvalid same cycle: capture mem_rdata, retire, -> IDLE.
- RESP: mem_req=0; on mem_rvalid capture mem_rdata into wb_rdata, retire, -> IDLE. rvalid outside RESP/REQ-read ignored.
- Minimum memory op latency: accept T, gnt T+1, retire visible T+2 (write or 0-latency read).
- Branch: branch_taken = accept & M[2] & cond; 0 otherwise (no latch). cond: EQ(0) zr; LT(1) neg^ov; GT(2) !zr&!(neg^ov); OV(3) ov; NE(4) !zr; GE(5) !(neg^ov); LE(6) zr|(neg^ov); UNCOND(7) 1.
- wb_valid deasserts the cycle after a retirement unless another instruction retires.

Optional Feature:
MEM_TIMEOUT_EN: counter clears on entering REQ, increments each cycle in REQ/RESP; on reaching TIMEOUT_CYC-1 without completion: drop mem_req, -> IDLE, retire with wb_err=1, wb_rdata=0. wb_err clears on the next retirement. Without the macro: no counter, waits indefinitely, wb_err tied 0.

Decomposition:
- Package cpu_pkg: bcond enum (EQ..UNCOND), M bit-index constants, mem FSM state enum, flag bit indices.
- Sub-module branch_eval (flags, bcond -> cond) is combinational, reused by future EX-stage early resolution.

Test Plan:
- ALU op (M=0, alu_in=16'h1234) accepted -> next cycle wb_valid=1, wb_alu=16'h1234, in_ready stays 1.
- Load addr=16'h0040, gnt after 2 cycles, rvalid 3 cycles later with 16'hBEEF -> in_ready low for 5 cycles, wb_rdata=16'hBEEF, pc_ret=16'hBEEF, one wb_valid pulse.
- Store with immediate gnt -> mem_we=1, mem_addr/wdata stable through gnt, retire at T+2, no stall beyond 1 cycle.
- Branch sweep: all 8 bcond × 8 flag combos with M[2]=1 -> branch_taken matches table; M[2]=0 -> 0 always.
- rst_n low while in RESP -> mem_req, wb_valid 0 at once; after release, IDLE and in_ready=1; late rvalid ignored.
- MEM_TIMEOUT_EN, TIMEOUT_CYC=8, gnt never arrives -> abort after 8 cycles, wb_valid=1, wb_err=1, wb_rdata=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types: branch conditions, M bits, MEM FSM states, flag indices
package cpu_pkg;

   typedef enum logic [2:0] {
      BC_EQ     = 3'd0,
      BC_LT     = 3'd1,
      BC_GT     = 3'd2,
      BC_OV     = 3'd3,
      BC_NE     = 3'd4,
      BC_GE     = 3'd5,
      BC_LE     = 3'd6,
      BC_UNCOND = 3'd7
   } bcond_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } mem_state_e;

   localparam int M_RD = 0;
   localparam int M_WR = 1;
   localparam int M_BR = 2;

   // flags vector is packed as {ov,neg,zr}
   localparam int FLAG_ZR  = 0;
   localparam int FLAG_NEG = 1;
   localparam int FLAG_OV  = 2;

endpackage

// File: rtl/branch_eval.sv
// rtl/branch_eval.sv - combinational branch condition evaluation from {ov,neg,zr} flags
module branch_eval
   import cpu_pkg::*;
(
   input  logic [2:0] i_flags,
   input  logic [2:0] i_bcond,
   output logic       o_cond
);

   logic w_lt;
   logic w_zr;

   assign w_lt = i_flags[FLAG_NEG] ^ i_flags[FLAG_OV];
   assign w_zr = i_flags[FLAG_ZR];

   always_comb begin
      o_cond = 1'b0;
      case (bcond_e'(i_bcond))
         BC_EQ:     o_cond = w_zr;
         BC_LT:     o_cond = w_lt;
         BC_GT:     o_cond = !w_zr && !w_lt;
         BC_OV:     o_cond = i_flags[FLAG_OV];
         BC_NE:     o_cond = !w_zr;
         BC_GE:     o_cond = !w_lt;
         BC_LE:     o_cond = w_zr || w_lt;
         BC_UNCOND: o_cond = 1'b1;
         default:   o_cond = 1'b0;
      endcase
   end

endmodule

// File: rtl/mem_stage_hs.sv
// rtl/mem_stage_hs.sv - MEM stage with req/gnt/rvalid data memory; optional abort via MEM_TIMEOUT_EN
module mem_stage_hs
   import cpu_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 16,
   parameter int PC_W        = 16,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        M,
   input  logic [1:0]        wb_ctrl_in,
   input  logic [2:0]        flags_in,
   input  logic [2:0]        bcond,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [PC_W-1:0]   pcbranch_in,
   input  logic [DATA_W-1:0] alu_in,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              branch_taken,
   output logic [PC_W-1:0]   pc_branch,
   output logic              wb_valid,
   output logic [1:0]        wb_ctrl,
   output logic [DATA_W-1:0] wb_alu,
   output logic [DATA_W-1:0] wb_rdata,
   output logic [PC_W-1:0]   pc_ret,
   output logic              wb_err
);

   mem_state_e        r_state;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [1:0]        r_ctrl;
   logic [DATA_W-1:0] r_alu;
   logic              r_wb_valid;
   logic [1:0]        r_wb_ctrl;
   logic [DATA_W-1:0] r_wb_alu;
   logic [DATA_W-1:0] r_wb_rdata;

   logic w_accept, w_memop, w_cond;
   logic w_done_req, w_done_resp, w_rd_done, w_abort, w_retire, w_timeout;

   branch_eval u_branch_eval (
      .i_flags (flags_in),
      .i_bcond (bcond),
      .o_cond  (w_cond)
   );

   assign in_ready     = (r_state == ST_IDLE);
   assign w_accept     = in_valid && in_ready;
   assign w_memop      = M[M_RD] || M[M_WR];
   assign branch_taken = w_accept && M[M_BR] && w_cond;
   assign pc_branch    = pcbranch_in;

   assign w_done_req  = (r_state == ST_REQ) && mem_gnt && (r_we || mem_rvalid);
   assign w_done_resp = (r_state == ST_RESP) && mem_rvalid;
   assign w_rd_done   = ((r_state == ST_REQ) && mem_gnt && !r_we && mem_rvalid) || w_done_resp;
   assign w_abort     = (r_state != ST_IDLE) && w_timeout && !(w_done_req || w_done_resp);
   assign w_retire    = (w_accept && !w_memop) || w_done_req || w_done_resp || w_abort;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] r_tcnt;
   logic             r_wb_err;

   assign w_timeout = (r_tcnt == CNT_W'(TIMEOUT_CYC - 1));
   assign wb_err    = r_wb_err;

   // Held at zero while idle, so the count starts from 0 on entry to REQ.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tcnt   <= '0;
         r_wb_err <= 1'b0;
      end else begin
         if (r_state == ST_IDLE || w_abort) r_tcnt <= '0;
         else                               r_tcnt <= r_tcnt + CNT_W'(1);
         if (w_retire) r_wb_err <= w_abort;
      end
   end
`else
   // No abort path: an outstanding access waits for the memory indefinitely.
   assign w_timeout = 1'b0 && (TIMEOUT_CYC > 0);
   assign wb_err    = 1'b0;
`endif

   assign mem_req   = (r_state == ST_REQ);
   assign mem_we    = mem_req && r_we;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign wb_valid  = r_wb_valid;
   assign wb_ctrl   = r_wb_ctrl;
   assign wb_alu    = r_wb_alu;
   assign wb_rdata  = r_wb_rdata;
   assign pc_ret    = r_wb_rdata[PC_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_ctrl     <= '0;
         r_alu      <= '0;
         r_wb_valid <= 1'b0;
         r_wb_ctrl  <= '0;
         r_wb_alu   <= '0;
         r_wb_rdata <= '0;
      end else begin
         r_wb_valid <= w_retire;
         if (w_accept && !w_memop) begin
            r_wb_alu  <= alu_in;
            r_wb_ctrl <= wb_ctrl_in;
         end else if (w_retire) begin
            r_wb_alu  <= r_alu;
            r_wb_ctrl <= r_ctrl;
         end
         if (w_abort)        r_wb_rdata <= '0;
         else if (w_rd_done) r_wb_rdata <= mem_rdata;

         case (r_state)
            ST_IDLE: if (w_accept && w_memop) begin
               r_we    <= M[M_WR];
               r_addr  <= addr;
               r_wdata <= wdata;
               r_ctrl  <= wb_ctrl_in;
               r_alu   <= alu_in;
               r_state <= ST_REQ;
            end
            ST_REQ: begin
               if (w_abort || w_done_req) r_state <= ST_IDLE;
               else if (mem_gnt)          r_state <= ST_RESP;
            end
            ST_RESP: if (w_abort || w_done_resp) r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_hs.sv
// tb/tb_mem_stage_hs.sv - directed self-checking bench for mem_stage_hs
module tb_mem_stage_hs;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  M = '0;
   logic [1:0]  wb_ctrl_in = '0;
   logic [2:0]  flags_in = '0;
   logic [2:0]  bcond = '0;
   logic [15:0] addr = '0;
   logic [15:0] wdata = '0;
   logic [15:0] pcbranch_in = '0;
   logic [15:0] alu_in = '0;
   logic        mem_req, mem_we;
   logic [15:0] mem_addr, mem_wdata;
   logic        mem_gnt = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [15:0] mem_rdata = '0;
   logic        branch_taken;
   logic [15:0] pc_branch;
   logic        wb_valid;
   logic [1:0]  wb_ctrl;
   logic [15:0] wb_alu, wb_rdata, pc_ret;
   logic        wb_err;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_stage_hs #(.DATA_W(16), .ADDR_W(16), .PC_W(16), .TIMEOUT_CYC(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .M(M),
      .wb_ctrl_in(wb_ctrl_in), .flags_in(flags_in), .bcond(bcond), .addr(addr),
      .wdata(wdata), .pcbranch_in(pcbranch_in), .alu_in(alu_in), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .branch_taken(branch_taken),
      .pc_branch(pc_branch), .wb_valid(wb_valid), .wb_ctrl(wb_ctrl), .wb_alu(wb_alu),
      .wb_rdata(wb_rdata), .pc_ret(pc_ret), .wb_err(wb_err)
   );

   task automatic cyc;
      @(posedge clk);
      #2;
   endtask

   function automatic logic bexp(input logic [2:0] bc, input logic [2:0] f);
      logic ov, ng, zr, lt;
      ov = f[2]; ng = f[1]; zr = f[0]; lt = ng ^ ov;
      case (bc)
         3'd0: return zr;
         3'd1: return lt;
         3'd2: return !zr && !lt;
         3'd3: return ov;
         3'd4: return !zr;
         3'd5: return !lt;
         3'd6: return zr || lt;
         default: return 1'b1;
      endcase
   endfunction

   task automatic test_reset;
      #3;
      n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
      n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_wb_valid: got %b want 0", wb_valid); end
      n_checks++; if (wb_err !== 1'b0) begin n_fail++; $display("FAIL rst_wb_err: got %b want 0", wb_err); end
      n_checks++; if ({wb_ctrl, wb_alu, wb_rdata} !== 34'd0) begin n_fail++; $display("FAIL rst_wb_regs: got %h want 0", {wb_ctrl, wb_alu, wb_rdata}); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
      cyc();
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_alu;
      in_valid = 1; M = 3'b000; alu_in = 16'h1234; wb_ctrl_in = 2'b10;
      cyc();
      in_valid = 0;
      n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL alu_wb_valid: got %b want 1", wb_valid); end
      n_checks++; if (wb_alu !== 16'h1234) begin n_fail++; $display("FAIL alu_wb_alu: got %h want 1234", wb_alu); end
      n_checks++; if (wb_ctrl !== 2'b10) begin n_fail++; $display("FAIL alu_wb_ctrl: got %b want 10", wb_ctrl); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL alu_in_ready: got %b want 1", in_ready); end
      cyc();
      n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL alu_wb_valid_drop: got %b want 0", wb_valid); end
   endtask

   task automatic test_back_to_back;
      in_valid = 1; M = 3'b000; alu_in = 16'h0001; wb_ctrl_in = 2'b01;
      cyc();
      alu_in = 16'h0002; wb_ctrl_in = 2'b11;
      n_checks++; if (wb_alu !== 16'h0001 || wb_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_first: got %b/%h want 1/0001", wb_valid, wb_alu); end
      cyc();
      in_valid = 0;
      n_checks++; if (wb_alu !== 16'h0002 || wb_valid !== 1'b1 || wb_ctrl !== 2'b11) begin n_fail++; $display("FAIL b2b_second: got %b/%h/%b want 1/0002/11", wb_valid, wb_alu, wb_ctrl); end
      cyc();
   endtask

   task automatic test_load;
      int low_cnt, early_valid;
      low_cnt = 0; early_valid = 0;
      in_valid = 1; M = 3'b001; addr = 16'h0040; alu_in = 16'h0A0A; wb_ctrl_in = 2'b01;
      cyc();
      // T+1: request outstanding; a branch presented now must not be taken
      M = 3'b100; bcond = 3'd7;
      #1;
      n_checks++; if (branch_taken !== 1'b0) begin n_fail++; $display("FAIL br_stalled: got %b want 0", branch_taken); end
      in_valid = 0; M = 3'b000; addr = 16'hFFFF;
      n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0040) begin n_fail++; $display("FAIL ld_req: got %b/%b/%h want 1/0/0040", mem_req, mem_we, mem_addr); end
      for (int i = 1; i <= 5; i++) begin
         if (in_ready === 1'b0) low_cnt++;
         if (wb_valid !== 1'b0) early_valid++;
         mem_gnt    = (i == 2);
         mem_rvalid = (i == 5);
         mem_rdata  = (i == 5) ? 16'hBEEF : 16'h0000;
         if (i == 3) begin
            n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL ld_resp_req: got %b want 0", mem_req); end
         end
         cyc();
      end
      mem_gnt = 0; mem_rvalid = 0;
      n_checks++; if (low_cnt !== 5) begin n_fail++; $display("FAIL ld_stall_cycles: got %0d want 5", low_cnt); end
      n_checks++; if (early_valid !== 0) begin n_fail++; $display("FAIL ld_early_valid: got %0d want 0", early_valid); end
      n_checks++; if (wb_valid !== 1'b1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL ld_retire: got %b/%b want 1/1", wb_valid, in_ready); end
      n_checks++; if (wb_rdata !== 16'hBEEF || pc_ret !== 16'hBEEF) begin n_fail++; $display("FAIL ld_rdata: got %h/%h want BEEF/BEEF", wb_rdata, pc_ret); end
      n_checks++; if (wb_alu !== 16'h0A0A || wb_ctrl !== 2'b01) begin n_fail++; $display("FAIL ld_passthru: got %h/%b want 0A0A/01", wb_alu, wb_ctrl); end
      cyc();
      n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL ld_single_pulse: got %b want 0", wb_valid); end
   endtask

   task automatic test_store;
      // M=3'b011 checks read+write is treated as a write; rvalid is ignored
      logic [2:0] ms [2];
      ms[0] = 3'b010; ms[1] = 3'b011;
      for (int k = 0; k < 2; k++) begin
         in_valid = 1; M = ms[k]; addr = 16'h0080; wdata = 16'hCAFE; alu_in = 16'h5555;
         cyc();
         in_valid = 0; M = 3'b000; addr = 16'hFFFF; wdata = 16'h0000;
         mem_gnt = 1; mem_rvalid = 1; mem_rdata = 16'h1111;
         #1;
         n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin n_fail++; $display("FAIL st_req_we[%0d]: got %b/%b want 1/1", k, mem_req, mem_we); end
         n_checks++; if (mem_addr !== 16'h0080 || mem_wdata !== 16'hCAFE) begin n_fail++; $display("FAIL st_payload[%0d]: got %h/%h want 0080/CAFE", k, mem_addr, mem_wdata); end
         n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL st_stall[%0d]: got %b want 0", k, in_ready); end
         cyc();
         mem_gnt = 0; mem_rvalid = 0;
         n_checks++; if (wb_valid !== 1'b1 || in_ready !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL st_retire[%0d]: got %b/%b/%b want 1/1/0", k, wb_valid, in_ready, mem_req); end
         n_checks++; if (wb_rdata !== 16'hBEEF || wb_alu !== 16'h5555) begin n_fail++; $display("FAIL st_wb[%0d]: got %h/%h want BEEF/5555", k, wb_rdata, wb_alu); end
         cyc();
      end
   endtask

   task automatic test_zero_latency_read;
      in_valid = 1; M = 3'b001; addr = 16'h0010;
      cyc();
      in_valid = 0; M = 3'b000;
      mem_gnt = 1; mem_rvalid = 1; mem_rdata = 16'h5A5A;
      cyc();
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = 16'h0000;
      n_checks++; if (wb_valid !== 1'b1 || wb_rdata !== 16'h5A5A) begin n_fail++; $display("FAIL zl_read: got %b/%h want 1/5A5A", wb_valid, wb_rdata); end
      cyc();
   endtask

   task automatic test_branch;
      int bad_t, bad_n;
      bad_t = 0; bad_n = 0;
      in_valid = 1; pcbranch_in = 16'h3C00;
      for (int bc = 0; bc < 8; bc++) begin
         for (int f = 0; f < 8; f++) begin
            bcond = 3'(bc); flags_in = 3'(f); M = 3'b100;
            #1;
            n_checks++;
            if (branch_taken !== bexp(3'(bc), 3'(f))) begin
               n_fail++; bad_t++;
               $display("FAIL br_taken bc=%0d f=%03b: got %b want %b", bc, f, branch_taken, bexp(3'(bc), 3'(f)));
            end
            M = 3'b000;
            #1;
            n_checks++;
            if (branch_taken !== 1'b0) begin
               n_fail++; bad_n++;
               $display("FAIL br_not_branch bc=%0d f=%03b: got %b want 0", bc, f, branch_taken);
            end
            cyc();
         end
      end
      n_checks++; if (pc_branch !== 16'h3C00) begin n_fail++; $display("FAIL pc_branch: got %h want 3C00", pc_branch); end
      in_valid = 0;
      cyc();
   endtask

   task automatic test_reset_mid_access;
      for (int k = 0; k < 2; k++) begin
         in_valid = 1; M = 3'b001; addr = 16'h0020;
         cyc();
         in_valid = 0; M = 3'b000;
         if (k == 0) begin
            mem_gnt = 1;
            cyc();
            mem_gnt = 0;
         end
         n_checks++; if (mem_req !== (k == 1)) begin n_fail++; $display("FAIL rm_pre_req[%0d]: got %b want %b", k, mem_req, k == 1); end
         #1 rst_n = 0;
         #1;
         n_checks++; if (mem_req !== 1'b0 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL rm_drop[%0d]: got %b/%b want 0/0", k, mem_req, wb_valid); end
         n_checks++; if (wb_rdata !== 16'h0000 || wb_alu !== 16'h0000) begin n_fail++; $display("FAIL rm_regs[%0d]: got %h/%h want 0/0", k, wb_rdata, wb_alu); end
         cyc();
         rst_n = 1;
         #1;
         n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rm_ready[%0d]: got %b want 1", k, in_ready); end
         mem_rvalid = 1; mem_rdata = 16'hDEAD;
         cyc();
         mem_rvalid = 0;
         n_checks++; if (wb_valid !== 1'b0 || wb_rdata !== 16'h0000) begin n_fail++; $display("FAIL rm_late_rvalid[%0d]: got %b/%h want 0/0000", k, wb_valid, wb_rdata); end
         cyc();
      end
   endtask

   task automatic test_timeout;
      int req_low;
      req_low = 0;
      in_valid = 1; M = 3'b001; addr = 16'h0066; alu_in = 16'h7070;
      cyc();
      in_valid = 0; M = 3'b000;
`ifdef MEM_TIMEOUT_EN
      for (int i = 0; i < 8; i++) begin
         if (mem_req !== 1'b1) req_low++;
         cyc();
      end
      n_checks++; if (req_low !== 0) begin n_fail++; $display("FAIL to_req_held: got %0d low cycles want 0", req_low); end
      n_checks++; if (wb_valid !== 1'b1 || wb_err !== 1'b1) begin n_fail++; $display("FAIL to_abort: got %b/%b want 1/1", wb_valid, wb_err); end
      n_checks++; if (wb_rdata !== 16'h0000 || mem_req !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL to_state: got %h/%b/%b want 0000/0/1", wb_rdata, mem_req, in_ready); end
      in_valid = 1; alu_in = 16'h0001;
      cyc();
      in_valid = 0;
      n_checks++; if (wb_err !== 1'b0 || wb_valid !== 1'b1) begin n_fail++; $display("FAIL to_err_clear: got %b/%b want 0/1", wb_err, wb_valid); end
`else
      for (int i = 0; i < 70; i++) begin
         if (mem_req !== 1'b1 || wb_valid !== 1'b0) req_low++;
         cyc();
      end
      n_checks++; if (req_low !== 0) begin n_fail++; $display("FAIL nto_wait: got %0d bad cycles want 0", req_low); end
      mem_gnt = 1; mem_rvalid = 1; mem_rdata = 16'h7777;
      cyc();
      mem_gnt = 0; mem_rvalid = 0;
      n_checks++; if (wb_valid !== 1'b1 || wb_rdata !== 16'h7777 || wb_err !== 1'b0) begin n_fail++; $display("FAIL nto_done: got %b/%h/%b want 1/7777/0", wb_valid, wb_rdata, wb_err); end
`endif
      cyc();
   endtask

   initial begin
      test_reset();
      test_alu();
      test_back_to_back();
      test_load();
      test_store();
      test_zero_latency_read();
      test_branch();
      test_reset_mid_access();
      test_timeout();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
